path_checker: RTL and testbench
===============================

Name: path_checker

Overview:
- Synthesizable bus-path monitor. Compares the sampled address bus against a loaded sequence of expected addresses, each with a per-entry bit mask.
- Reports pass, fail, the failing step, and the expected and observed values at failure.
- Parametrised in address width, path depth and miss tolerance, with a strict/tolerant mode selected at run time.
- Sits beside the CPU core in simulation or emulation builds, snooping the address bus so path tests run without bench-side polling.

Parameters:
- ADDR_WIDTH, 16, width of the monitored address and of each expected entry.
- DEPTH, 256, number of expected-path entries; IDX_W = $clog2(DEPTH).
- MISS_LIMIT, 10, consecutive misses tolerated in tolerant mode; MISS_W = $clog2(MISS_LIMIT+2).

Ports:
- ph2  in  1  clock; all state updates on the rising edge.
- resetb  in  1  asynchronous, active-low reset.
- load_en  in  1  write one expected entry this cycle.
- load_idx  in  IDX_W  entry index to write.
- load_addr  in  ADDR_WIDTH  expected address.
- load_mask  in  ADDR_WIDTH  compare mask; 1 means the bit is compared.
- path_len  in  IDX_W+1  number of valid entries, sampled on start.
- strict  in  1  1 = any miss fails; 0 = tolerant. Sampled on start.
- start  in  1  begin or restart a check.
- bus_valid  in  1  bus_addr is a valid sample this cycle.
- bus_addr  in  ADDR_WIDTH  observed address.
- busy  out  1  check in progress.
- pass  out  1  sticky; whole path matched.
- fail  out  1  sticky; miss limit exceeded.
- step  out  IDX_W+1  index of the entry currently awaited.
- misses  out  MISS_W  consecutive misses on the current step.
- fail_expected  out  ADDR_WIDTH  expected entry at failure.
- fail_observed  out  ADDR_WIDTH  bus_addr at failure.

Behaviour:
- States: IDLE, RUN, PASS, FAIL. busy = (state == RUN); pass = (state == PASS); fail = (state == FAIL).
- Reset (resetb low, asynchronous):
  - State goes to IDLE.
  - Every output and internal counter is cleared: step = 0, misses = 0, fail_expected = 0, fail_observed = 0.
  - Path memory is not reset and keeps its contents across reset, including reset mid-run.
- Loading:
  - load_en writes {load_addr, load_mask} to entry load_idx at the rising edge.
  - Loading is accepted in IDLE, PASS and FAIL. In RUN it is ignored.
- Start:
  - start in any state latches path_len and strict, clears step, misses and the fail_* outputs, and enters RUN.
  - If the latched length is 0, it enters PASS instead.
  - If start and bus_valid are high in the same cycle, that sample is ignored.
  - If start and load_en are high in the same cycle and the state is not RUN, the write completes and is visible to the first compare.
- Match rule: ((bus_addr ^ exp_addr[step]) & exp_mask[step]) == 0. The memory read is combinational on step.
- RUN, bus_valid = 1, match:
  - step increments and misses clears.
  - If step+1 == latched length, go to PASS.
- RUN, bus_valid = 1, miss:
  - Strict mode: FAIL immediately.
  - Tolerant mode: misses increments; FAIL when the incremented count exceeds MISS_LIMIT, i.e. on miss number MISS_LIMIT+1.
  - On FAIL, capture fail_expected = exp_addr[step] and fail_observed = bus_addr. step holds the failing index.
- RUN, bus_valid = 0: no change.
- Latency: pass or fail is visible one cycle after the edge that sampled the deciding bus value.
- PASS and FAIL are held until start or reset. bus_valid is ignored in those states.
- Counters never wrap:
  - step maxes at DEPTH, since path_len is clamped to DEPTH on latch.
  - misses saturates at MISS_LIMIT+1.
- IDLE ignores bus_valid.

Test Plan:
- Load 4 entries {F000, F001, F002, 0042}, all masks FFFF. start with path_len = 4, strict = 0. Drive exactly that sequence with bus_valid. -> pass rises one cycle after the 4th sample; step = 4; misses = 0.
- Tolerant mode, same path. Insert 10 non-matching samples before F001. -> no fail; misses reaches 10 and then clears on the match; pass at the end. With 11 misses instead -> fail, step = 1, fail_expected = F001, fail_observed = the 11th bad value.
- strict = 1. First sample 1234 against expected F000. -> fail on the next cycle, step = 0, fail_observed = 1234.
- Mask FF00 on entry 0 (expected F000). Drive F0A5. -> accepted as a match; step becomes 1.
- Assert resetb low mid-run at step 2. -> all outputs 0 and state IDLE. After reset, start again without reloading; the full sequence passes, confirming memory was retained.
- path_len = 0 with start -> pass the next cycle. Also: start asserted during FAIL -> fail clears and busy = 1; load_en during RUN does not alter the entry that is read back.

Source files
------------

// File: rtl/path_checker_if.sv
// path_checker_if: load, run-control, bus-snoop and status signals of path_checker
interface path_checker_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int MISS_LIMIT = 10
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int MISS_W = $clog2(MISS_LIMIT + 2);
  logic                  load_en;
  logic [IDX_W-1:0]      load_idx;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [ADDR_WIDTH-1:0] load_mask;
  logic [IDX_W:0]        path_len;
  logic                  strict;
  logic                  start;
  logic                  bus_valid;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic                  busy;
  logic                  pass;
  logic                  fail;
  logic [IDX_W:0]        step;
  logic [MISS_W-1:0]     misses;
  logic [ADDR_WIDTH-1:0] fail_expected;
  logic [ADDR_WIDTH-1:0] fail_observed;
  modport master (
    output load_en, load_idx, load_addr, load_mask, path_len, strict, start, bus_valid, bus_addr,
    input  busy, pass, fail, step, misses, fail_expected, fail_observed
  );
  modport slave (
    input  load_en, load_idx, load_addr, load_mask, path_len, strict, start, bus_valid, bus_addr,
    output busy, pass, fail, step, misses, fail_expected, fail_observed
  );
endinterface

// File: rtl/path_checker.sv
// path_checker: snoops the address bus and checks it against a loaded masked address path
module path_checker #(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int MISS_LIMIT = 10
) (
  input logic          ph2,
  input logic          resetb,
  path_checker_if.slave io
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int MISS_W = $clog2(MISS_LIMIT + 2);
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
  state_t                state_q, state_d;
  logic [IDX_W:0]        len_q, len_d, step_q, step_d, len_clamp, step_inc;
  logic                  strict_q, strict_d;
  logic [MISS_W-1:0]     misses_q, misses_d, miss_inc;
  logic [ADDR_WIDTH-1:0] fexp_q, fexp_d, fobs_q, fobs_d, cur_addr, cur_mask;
  logic [ADDR_WIDTH-1:0] exp_addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] exp_mask_q [DEPTH];
  logic                  hit;
  // Lengths beyond the memory are clamped so step can never run past DEPTH
  assign len_clamp = (io.path_len > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : io.path_len;
  assign cur_addr  = exp_addr_q[step_q[IDX_W-1:0]];
  assign cur_mask  = exp_mask_q[step_q[IDX_W-1:0]];
  assign hit       = ((io.bus_addr ^ cur_addr) & cur_mask) == '0;
  assign step_inc  = step_q + (IDX_W+1)'(1);
  assign miss_inc  = misses_q + MISS_W'(1);
  assign io.busy          = state_q == RUN;
  assign io.pass          = state_q == PASS;
  assign io.fail          = state_q == FAIL;
  assign io.step          = step_q;
  assign io.misses        = misses_q;
  assign io.fail_expected = fexp_q;
  assign io.fail_observed = fobs_q;
  // Path memory: unreset, writable only while no check is running
  always_ff @(posedge ph2) begin
    if (io.load_en && state_q != RUN) begin
      exp_addr_q[io.load_idx] <= io.load_addr;
      exp_mask_q[io.load_idx] <= io.load_mask;
    end
  end
  // Next-state: start overrides everything; otherwise only valid samples in RUN advance the check
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    strict_d = strict_q;
    step_d   = step_q;
    misses_d = misses_q;
    fexp_d   = fexp_q;
    fobs_d   = fobs_q;
    if (io.start) begin
      len_d    = len_clamp;
      strict_d = io.strict;
      step_d   = '0;
      misses_d = '0;
      fexp_d   = '0;
      fobs_d   = '0;
      state_d  = (len_clamp == '0) ? PASS : RUN;
    end else if (state_q == RUN && io.bus_valid) begin
      if (hit) begin
        step_d   = step_inc;
        misses_d = '0;
        state_d  = (step_inc == len_q) ? PASS : RUN;
      end else begin
        misses_d = strict_q ? misses_q : miss_inc;
        if (strict_q || miss_inc > MISS_W'(MISS_LIMIT)) begin
          state_d = FAIL;
          fexp_d  = cur_addr;
          fobs_d  = io.bus_addr;
        end
      end
    end
  end
  // Control and status registers
  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      state_q  <= IDLE;
      len_q    <= '0;
      strict_q <= 1'b0;
      step_q   <= '0;
      misses_q <= '0;
      fexp_q   <= '0;
      fobs_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      strict_q <= strict_d;
      step_q   <= step_d;
      misses_q <= misses_d;
      fexp_q   <= fexp_d;
      fobs_q   <= fobs_d;
    end
  end
endmodule

// File: tb/tb_path_checker.sv
// tb_path_checker: table, directed and random checks of path_checker against a behavioural model
module tb_path_checker;
  localparam int AW = 16, DEPTH = 256, ML = 10;
  logic ph2 = 1'b0;
  logic resetb = 1'b0;
  always #5 ph2 = ~ph2;
  path_checker_if #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .MISS_LIMIT(ML)) pif();
  path_checker #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .MISS_LIMIT(ML)) dut (.ph2(ph2), .resetb(resetb), .io(pif));
  int n_cmp = 0, n_bad = 0;
  logic [AW-1:0] mem_a [DEPTH];
  logic [AW-1:0] mem_m [DEPTH];
  int m_st, m_len, m_step, m_miss;
  bit m_strict;
  logic [AW-1:0] m_fe, m_fo;
  typedef struct {
    logic st; logic [8:0] len; logic bv; logic [15:0] a;
    logic e_busy; logic e_pass; logic [8:0] e_step; logic [3:0] e_miss;
  } vec_t;
  vec_t tbl [8];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_st = 0; m_len = 0; m_step = 0; m_miss = 0; m_strict = 0; m_fe = '0; m_fo = '0;
  endtask
  // State codes: 0 idle, 1 running, 2 passed, 3 failed
  task automatic model_edge();
    if (pif.load_en && m_st != 1) begin
      mem_a[pif.load_idx] = pif.load_addr;
      mem_m[pif.load_idx] = pif.load_mask;
    end
    if (pif.start) begin
      m_len = (int'(pif.path_len) > DEPTH) ? DEPTH : int'(pif.path_len);
      m_strict = pif.strict; m_step = 0; m_miss = 0; m_fe = '0; m_fo = '0;
      m_st = (m_len == 0) ? 2 : 1;
    end else if (m_st == 1 && pif.bus_valid) begin
      if (((pif.bus_addr ^ mem_a[m_step]) & mem_m[m_step]) == '0) begin
        m_step++; m_miss = 0;
        if (m_step == m_len) m_st = 2;
      end else begin
        if (!m_strict) m_miss++;
        if (m_strict || m_miss > ML) begin
          m_st = 3; m_fe = mem_a[m_step]; m_fo = pif.bus_addr;
        end
      end
    end
  endtask
  task automatic compare_all();
    chk("busy", pif.busy, m_st == 1);
    chk("pass", pif.pass, m_st == 2);
    chk("fail", pif.fail, m_st == 3);
    chk("step", pif.step, m_step);
    chk("misses", pif.misses, m_miss);
    chk("fail_expected", pif.fail_expected, m_fe);
    chk("fail_observed", pif.fail_observed, m_fo);
  endtask
  task automatic cycle();
    model_edge();
    @(posedge ph2);
    #1;
    compare_all();
  endtask
  task automatic load(int idx, logic [AW-1:0] a, logic [AW-1:0] m);
    pif.load_en = 1'b1; pif.load_idx = 8'(idx); pif.load_addr = a; pif.load_mask = m;
    cycle();
    pif.load_en = 1'b0;
  endtask
  task automatic do_start(int len, bit s);
    pif.start = 1'b1; pif.path_len = 9'(len); pif.strict = s;
    cycle();
    pif.start = 1'b0;
  endtask
  task automatic drive(logic [AW-1:0] a);
    pif.bus_valid = 1'b1; pif.bus_addr = a;
    cycle();
    pif.bus_valid = 1'b0;
  endtask
  task automatic drive_path();
    drive(16'hF000); drive(16'hF001); drive(16'hF002); drive(16'h0042);
  endtask
  initial begin
    pif.load_en = 0; pif.load_idx = '0; pif.load_addr = '0; pif.load_mask = '0;
    pif.path_len = '0; pif.strict = 0; pif.start = 0; pif.bus_valid = 0; pif.bus_addr = '0;
    model_reset();
    #2;
    chk("rst_busy", pif.busy, 0);
    chk("rst_pass", pif.pass, 0);
    chk("rst_fail", pif.fail, 0);
    chk("rst_step", pif.step, 0);
    chk("rst_misses", pif.misses, 0);
    @(posedge ph2);
    #1;
    resetb = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      load(i, (i == 0) ? 16'hF000 : (i == 1) ? 16'hF001 : (i == 2) ? 16'hF002 : (i == 3) ? 16'h0042 : 16'($urandom), 16'hFFFF);
    tbl[0] = '{1'b1, 9'd4, 1'b1, 16'hF000, 1'b1, 1'b0, 9'd0, 4'd0};
    tbl[1] = '{1'b0, 9'd0, 1'b1, 16'hF000, 1'b1, 1'b0, 9'd1, 4'd0};
    tbl[2] = '{1'b0, 9'd0, 1'b1, 16'hF001, 1'b1, 1'b0, 9'd2, 4'd0};
    tbl[3] = '{1'b0, 9'd0, 1'b1, 16'h1111, 1'b1, 1'b0, 9'd2, 4'd1};
    tbl[4] = '{1'b0, 9'd0, 1'b1, 16'hF002, 1'b1, 1'b0, 9'd3, 4'd0};
    tbl[5] = '{1'b0, 9'd0, 1'b0, 16'h0042, 1'b1, 1'b0, 9'd3, 4'd0};
    tbl[6] = '{1'b0, 9'd0, 1'b1, 16'h0042, 1'b0, 1'b1, 9'd4, 4'd0};
    tbl[7] = '{1'b0, 9'd0, 1'b1, 16'hF000, 1'b0, 1'b1, 9'd4, 4'd0};
    foreach (tbl[i]) begin
      pif.start = tbl[i].st; pif.path_len = tbl[i].len; pif.strict = 0;
      pif.bus_valid = tbl[i].bv; pif.bus_addr = tbl[i].a;
      cycle();
      chk($sformatf("tbl%0d_busy", i), pif.busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_pass", i), pif.pass, tbl[i].e_pass);
      chk($sformatf("tbl%0d_step", i), pif.step, tbl[i].e_step);
      chk($sformatf("tbl%0d_misses", i), pif.misses, tbl[i].e_miss);
    end
    pif.start = 0; pif.bus_valid = 0;
    do_start(4, 0);
    drive(16'hF000);
    repeat (10) drive(16'h1234);
    chk("tol10_misses", pif.misses, 10);
    chk("tol10_fail", pif.fail, 0);
    drive(16'hF001);
    chk("tol10_clear", pif.misses, 0);
    drive(16'hF002); drive(16'h0042);
    chk("tol10_pass", pif.pass, 1);
    do_start(4, 0);
    drive(16'hF000);
    for (int i = 0; i < 11; i++) drive(16'h2000 + 16'(i));
    chk("tol11_fail", pif.fail, 1);
    chk("tol11_step", pif.step, 1);
    chk("tol11_fexp", pif.fail_expected, 16'hF001);
    chk("tol11_fobs", pif.fail_observed, 16'h200A);
    do_start(4, 1);
    drive(16'h1234);
    chk("strict_fail", pif.fail, 1);
    chk("strict_step", pif.step, 0);
    chk("strict_fexp", pif.fail_expected, 16'hF000);
    chk("strict_fobs", pif.fail_observed, 16'h1234);
    do_start(4, 0);
    chk("restart_busy", pif.busy, 1);
    chk("restart_fail", pif.fail, 0);
    load(1, 16'hDEAD, 16'hFFFF);
    drive(16'hF000); drive(16'hF001);
    chk("runload_step", pif.step, 2);
    drive(16'hF002); drive(16'h0042);
    chk("runload_pass", pif.pass, 1);
    load(0, 16'hF000, 16'hFF00);
    do_start(4, 0);
    drive(16'hF0A5);
    chk("mask_step", pif.step, 1);
    do_start(0, 0);
    chk("len0_pass", pif.pass, 1);
    chk("len0_step", pif.step, 0);
    load(0, 16'hF000, 16'hFFFF);
    do_start(4, 0);
    drive(16'hF000); drive(16'hF001);
    chk("prerst_step", pif.step, 2);
    resetb = 1'b0;
    #2;
    model_reset();
    chk("midrst_busy", pif.busy, 0);
    chk("midrst_step", pif.step, 0);
    chk("midrst_fexp", pif.fail_expected, 0);
    #2;
    resetb = 1'b1;
    do_start(4, 0);
    drive_path();
    chk("retain_pass", pif.pass, 1);
    chk("retain_step", pif.step, 4);
    for (int i = 0; i < 4000; i++) begin
      pif.start = $urandom_range(0, 39) == 0;
      pif.path_len = ($urandom_range(0, 19) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 8));
      pif.strict = $urandom_range(0, 3) == 0;
      pif.load_en = $urandom_range(0, 7) == 0;
      pif.load_idx = 8'($urandom_range(0, 7));
      pif.load_addr = 16'hA500 | 16'($urandom_range(0, 3));
      pif.load_mask = ($urandom_range(0, 3) == 0) ? 16'hFFF0 : 16'hFFFF;
      pif.bus_valid = $urandom_range(0, 2) != 0;
      pif.bus_addr = ($urandom_range(0, 1) == 1) ? mem_a[m_step % DEPTH] : (16'hA500 | 16'($urandom_range(0, 7)));
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
